// File: rtl/serial_xfer_pkg.sv
// Shared definitions for the serial_xfer bit-serial transceiver.
package serial_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_xfer.sv
// Bit-serial transceiver: shifts a parallel word out on x while reassembling
// the leaf's returned y stream into rx_data, pulsing done when complete.
module serial_xfer
    import serial_xfer_pkg::*;
#(
    parameter int W         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    output logic         x,
    input  logic         y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rx_data
);

    localparam int CW = $clog2(W);

    if (W < 2) begin : g_bad_width
        $error("serial_xfer: W must be at least 2");
    end

    state_e          state_q, state_d;
    logic [W-1:0]    tx_q, tx_d;
    logic [W-1:0]    rx_q, rx_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    rx_shifted;
    logic [W-1:0]    tx_shifted;

    // y enters at the end opposite the one x leaves from, so the received word
    // lines up with the transmitted one under loopback.
    assign rx_shifted = LSB_FIRST ? {y, rx_q[W-1:1]} : {rx_q[W-2:0], y};
    assign tx_shifted = LSB_FIRST ? {1'b0, tx_q[W-1:1]} : {tx_q[W-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    tx_d    = load_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                rx_d = rx_shifted;
                tx_d = tx_shifted;
                if (cnt_q == CW'(W - 1)) begin
                    rx_data_d = rx_shifted;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decode registered state only; no input reaches x combinationally.
    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign x          = (state_q == ST_SHIFT) ? (LSB_FIRST ? tx_q[0] : tx_q[W-1]) : 1'b0;
    assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_serial_xfer.sv
// Scoreboard bench for serial_xfer: three instances (W=8 MSB-first,
// W=8 LSB-first, W=2 MSB-first) exercised one at a time through a selector.
module tb_serial_xfer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       lv;
    logic [7:0] load_data;
    logic       yloop;
    logic       y_drv;
    int         sel;

    logic       lv0, lv1, lv2;
    logic       r0, r1, r2, x0, x1, x2, b0, b1, b2, d0, d1, d2;
    logic       y0, y1, y2;
    logic [7:0] rx0, rx1;
    logic [1:0] rx2;

    assign lv0 = lv && (sel == 0);
    assign lv1 = lv && (sel == 1);
    assign lv2 = lv && (sel == 2);
    assign y0  = yloop ? x0 : y_drv;
    assign y1  = yloop ? x1 : y_drv;
    assign y2  = yloop ? x2 : y_drv;

    serial_xfer #(.W(8), .LSB_FIRST(1'b0)) u_msb8 (
        .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(r0), .load_data(load_data),
        .x(x0), .y(y0), .busy(b0), .done(d0), .rx_data(rx0));
    serial_xfer #(.W(8), .LSB_FIRST(1'b1)) u_lsb8 (
        .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(r1), .load_data(load_data),
        .x(x1), .y(y1), .busy(b1), .done(d1), .rx_data(rx1));
    serial_xfer #(.W(2), .LSB_FIRST(1'b0)) u_msb2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(r2), .load_data(load_data[1:0]),
        .x(x2), .y(y2), .busy(b2), .done(d2), .rx_data(rx2));

    logic       m_ready, m_x, m_busy, m_done, lsb;
    logic [7:0] m_rx, mask;
    int         cur_w;

    always_comb begin
        m_ready = r0; m_x = x0; m_busy = b0; m_done = d0; m_rx = rx0;
        cur_w = 8; lsb = 1'b0; mask = 8'hFF;
        if (sel == 1) begin
            m_ready = r1; m_x = x1; m_busy = b1; m_done = d1; m_rx = rx1; lsb = 1'b1;
        end else if (sel == 2) begin
            m_ready = r2; m_x = x2; m_busy = b2; m_done = d2; m_rx = {6'b0, rx2};
            cur_w = 2; mask = 8'h03;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d, dut %0d)", name, act, req, cyc, sel);
    endfunction

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         done_cyc;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: reassembles x from the wire and compares at every done pulse.
    exp_t       e_m;
    logic [7:0] xw = 8'h00;
    int         nbits = 0;
    bit         chk_ready = 1'b0;

    always @(negedge clk) begin
        if (chk_ready) begin
            chk_ready = 1'b0;
            if (!rst) check("ready_after_done", 32'(m_ready), 32'd1);
        end
        if (!m_busy) begin
            xw = 8'h00;
            nbits = 0;
        end else if (!m_done) begin
            if (lsb) xw = xw | (8'(m_x) << nbits);
            else     xw = {xw[6:0], m_x};
            nbits++;
        end else begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e_m = exp_q.pop_front();
                $display("done: dut %0d rx_data=%0h x_word=%0h cycle %0d", sel, m_rx, xw, cyc);
                check("rx_data", 32'(m_rx), 32'(e_m.rx));
                check("x_word", 32'(xw), 32'(e_m.tx));
                check("x_bits", 32'(nbits), 32'(cur_w));
                check("done_cycle", 32'(cyc), 32'(e_m.done_cyc));
            end
            chk_ready = 1'b1;
        end
    end

    // Called on a negedge; returns on the negedge of the done cycle.
    task automatic send(input logic [7:0] d, input bit loop, input logic [7:0] yw,
                        input bit keep, input bit pulse99, output int acc);
        int t;
        load_data = d;
        lv        = 1'b1;
        yloop     = loop;
        t = 0;
        while (!m_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        acc = cyc;
        if (!m_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            lv = 1'b0;
        end else begin
            exp_q.push_back('{tx: d & mask, rx: (loop ? d : yw) & mask, done_cyc: cyc + cur_w + 1});
            for (int k = 0; k < cur_w; k++) begin
                @(negedge clk);
                y_drv = lsb ? yw[k] : yw[cur_w - 1 - k];
                if (k == 0 && !keep) lv = 1'b0;
                if (pulse99 && k == 2) begin load_data = 8'h99; lv = 1'b1; end
                if (pulse99 && k == 3) begin load_data = d;     lv = 1'b0; end
            end
            @(negedge clk);
        end
    endtask

    task automatic random_run(input int n);
        int         a;
        logic [7:0] d, yw;
        bit         loop;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d    = 8'($urandom);
            yw   = 8'($urandom);
            loop = 1'($urandom_range(0, 1));
            send(d, loop, yw, 1'b0, 1'b0, a);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a, a1, a2;
        rst = 1'b1; lv = 1'b0; load_data = 8'h00; yloop = 1'b1; y_drv = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'({r0, r1, r2}), 32'b111);
        check("rst_busy",  32'({b0, b1, b2}), 32'b000);
        check("rst_done",  32'({d0, d1, d2}), 32'b000);
        check("rst_x",     32'({x0, x1, x2}), 32'b000);
        check("rst_rx",    32'({rx0, rx1, rx2}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // W=8 MSB-first directed cases
        send(8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, a);
        send(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, a);
        send(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, a);
        send(8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, a1);
        send(8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, a2);
        lv = 1'b0;
        check("accept_spacing", 32'(a2 - a1), 32'd10);
        @(negedge clk);
        send(8'h66, 1'b1, 8'h00, 1'b0, 1'b1, a);
        @(negedge clk);

        // Reset after the third shifted bit of 8'hA5
        load_data = 8'hA5; yloop = 1'b1; lv = 1'b1;
        @(negedge clk);
        lv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_x",     32'(x0),      32'd0);
        check("mid_rst_busy",  32'(b0),      32'd0);
        check("mid_rst_ready", 32'(r0),      32'd1);
        check("mid_rst_rx",    32'(rx0),     32'd0);
        repeat (12) @(negedge clk);
        send(8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, a);
        repeat (2) @(negedge clk);
        random_run(15);

        sel = 1;
        @(negedge clk);
        send(8'h01, 1'b1, 8'h00, 1'b0, 1'b0, a);
        repeat (2) @(negedge clk);
        random_run(15);

        sel = 2;
        @(negedge clk);
        send(8'h02, 1'b1, 8'h00, 1'b0, 1'b0, a);
        repeat (2) @(negedge clk);
        random_run(15);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
